// File: rtl/adc128s022_pkg.sv
// Shared constants, types and the address-bit helper for the ADC128S022 serial controller.
package adc128s022_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int DATA_BITS      = 12;
  localparam int LEAD_ZEROS     = 4;
  localparam int ADDR_FIRST_BIT = 2;

  typedef logic [2:0] adc_chan_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } adc_state_e;

  // DIN value for bit-slot k: the channel address MSB first in slots 2..4, zero elsewhere.
  function automatic logic addr_bit(input logic [3:0] k, input adc_chan_t ch);
    logic b;
    int   kk;
    b  = 1'b0;
    kk = int'(k);
    case (kk)
      ADDR_FIRST_BIT:     b = ch[2];
      ADDR_FIRST_BIT + 1: b = ch[1];
      ADDR_FIRST_BIT + 2: b = ch[0];
      default:            b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc128s022_ctrl_tick.sv
// SCLK half-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each half-period.
module adc_tick_gen #(
  parameter int CLK_DIV = 12
) (
  input  logic clock_50,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int              CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (restart || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/adc128s022_ctrl.sv
// ADC128S022 frame controller: one 16-SCLK frame per accepted start, pipelined channel addressing.
module adc128s022_ctrl
  import adc128s022_pkg::*;
#(
  parameter int CLK_DIV = 12
) (
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  channel,
  output logic        busy,
  output logic        done,
  output logic [11:0] sample,
  output logic [2:0]  sample_channel,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_saddr,
  input  logic        adc_sdat
);

  if (CLK_DIV < 8 || CLK_DIV > 31) begin : g_bad_clk_div
    $error("adc128s022_ctrl: CLK_DIV=%0d outside 8..31 (SCLK must stay within 0.8-3.2 MHz)", CLK_DIV);
  end

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  adc_state_e              state, state_next;
  logic [3:0]              bit_cnt, bit_next;
  logic                    half, half_next;      // 0 = SCLK low half, 1 = high half
  adc_chan_t               chan_lat, prev_channel;
  logic [DATA_BITS-1:0]    shreg;
  logic                    tick;
  logic                    cs_n_d, sclk_d, saddr_d;

  adc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .restart  (state_next != state),
    .tick     (tick)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      half    <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_next;
      half    <= half_next;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    half_next  = half;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (tick) begin
          state_next = ST_SHIFT;
          bit_next   = '0;
          half_next  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!half) begin
            half_next = 1'b1;
          end else begin
            half_next = 1'b0;
            bit_next  = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tick) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pin values are derived from the next state and registered, so the ADC sees glitch-free edges.
  always_comb begin
    cs_n_d  = !(state_next == ST_SETUP || state_next == ST_SHIFT);
    sclk_d  = !(state_next == ST_SHIFT && !half_next);
    saddr_d = (state_next == ST_SHIFT) ? addr_bit(bit_next, chan_lat) : 1'b0;
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b1;
      adc_saddr <= 1'b0;
    end else begin
      adc_cs_n  <= cs_n_d;
      adc_sclk  <= sclk_d;
      adc_saddr <= saddr_d;
    end
  end

  // adc_sdat is captured unsynchronized: its timing is fixed relative to the SCLK we generate.
  // Shifting all 16 bits into a 12-bit register lets the four leading zeros fall off the top.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      chan_lat       <= '0;
      prev_channel   <= '0;
      shreg          <= '0;
      sample         <= '0;
      sample_channel <= '0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE && start) chan_lat <= channel;
      if (state == ST_SHIFT && tick) begin
        if (!half) begin
          shreg <= {shreg[DATA_BITS-2:0], adc_sdat};
        end else if (bit_cnt == LAST_BIT) begin
          done           <= 1'b1;
          sample         <= shreg;
          sample_channel <= prev_channel;
          prev_channel   <= chan_lat;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/adc128s022_ctrl.md
Name: adc128s022_ctrl

Overview:
Serial controller for the board's ADC128S022 8-channel 12-bit ADC. It replaces the parked adc_cs_n/adc_sclk/adc_saddr/adc_sdat pins in top.
- On a start request it runs one 16-SCLK frame.
- It shifts the requested channel address out on adc_saddr and shifts the 12-bit conversion result in from adc_sdat.
- It presents the result with a one-cycle done pulse, for use by LED or counter logic in top.

Parameters:
CLK_DIV, 12, clock_50 cycles per SCLK half-period; 12 gives 2.083 MHz SCLK. Legal range is 8..31, checked by an elaboration-time assertion, which keeps SCLK within 0.8-3.2 MHz.

Ports:
clock_50  in  1  50 MHz system clock; all state on its rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  frame request; accepted only while busy=0
channel  in  3  channel to address in this frame; latched when start is accepted
busy  out  1  high from the cycle after acceptance until the controller returns to IDLE
done  out  1  one-cycle pulse; sample and sample_channel valid from this cycle
sample  out  12  conversion result, held until the next done
sample_channel  out  3  channel that sample belongs to (the address sent in the previous frame)
adc_cs_n  out  1  ADC chip select, active low
adc_sclk  out  1  ADC serial clock; idles high
adc_saddr  out  1  ADC DIN
adc_sdat  in  1  ADC DOUT

Behaviour:
- Reset values (asynchronous, also mid-frame): state=IDLE, adc_cs_n=1, adc_sclk=1, adc_saddr=0, busy=0, done=0, sample=0, sample_channel=0, prev_channel=0. A mid-frame reset simply aborts the frame; no partial result is reported.
- States: IDLE, SETUP, SHIFT, GAP. A tick counter counts 0..CLK_DIV-1 and restarts on every state change.
- IDLE: when start=1, latch channel, go to SETUP. Next cycle: cs_n=0, busy=1. A start while busy=1 is ignored; no queueing.
- SETUP: lasts 1 half-period with sclk high, then go to SHIFT.
- SHIFT: 16 bit-slots k=0..15. Each slot is 1 low half-period followed by 1 high half-period.
  - adc_sclk falls at the start of the slot.
  - adc_saddr updates on the fall: bits k=2,3,4 carry channel[2], channel[1], channel[0]; all other k carry 0.
  - adc_sdat is captured in the last clock of the low half-period, i.e. on the same clock_50 edge that raises adc_sclk.
  - Bits k=0..3 are the ADC's leading zeros and are discarded. Bits k=4..15 form sample[11:0], MSB first.
- End of SHIFT, after the high half of slot 15:
  - cs_n=1, sclk stays 1, saddr=0.
  - done=1 for exactly one cycle.
  - sample is updated; sample_channel=prev_channel, then prev_channel is set to the latched channel.
  - Go to GAP.
- GAP: lasts 1 half-period (CS high quiet time) with busy=1, then IDLE with busy=0.
- Timing: start accepted at cycle t -> cs_n low at t+1 -> done at t+1+33*CLK_DIV -> busy low at t+1+34*CLK_DIV. With the default CLK_DIV this is 408 cycles per frame, about 122.5 kS/s. Back-to-back frames are possible by holding start high.
- Pipeline: the first frame after reset returns sample_channel=0, because the ADC's power-up address is channel 0.
- adc_sdat is sampled directly with no synchronizer; its timing is fixed relative to adc_sclk.

Decomposition:
- Package adc128s022_pkg:
  - constants FRAME_BITS=16, DATA_BITS=12, LEAD_ZEROS=4, ADDR_FIRST_BIT=2
  - typedef adc_chan_t = logic [2:0]
  - state enum adc_state_e
- One sub-module, adc_tick_gen: half-period counter with restart input and tick output, parameterized by CLK_DIV.

Test Plan:
- Reset and idle: reset_n low 5 cycles, then idle 100 cycles -> adc_cs_n=1, adc_sclk=1, adc_saddr=0, busy=0, done=0, sample=0 throughout.
- Single frame: start=1 for 1 cycle with channel=5; ADC model returns 12'hA5C -> cs_n low for 33*12=396 cycles and saddr bits k2..4 = 1,0,1. Done pulses once, 397 cycles after acceptance, with sample=12'hA5C and sample_channel=0. busy falls 12 cycles after done.
- Pipelined addressing: frames with channels 3, 6, 1, model returning 12'h100+channel-of-previous-address -> sample_channel sequence 0, 3, 6; sample sequence 12'h100, 12'h103, 12'h106.
- Start while busy: pulse start with channel=7 at mid-frame cycle 200 -> ignored, no extra frame; next frame's saddr address equals the originally latched channel.
- Reset mid-frame: assert reset_n=0 at SHIFT slot 8 -> same cycle cs_n=1, sclk=1, busy=0, no done pulse. A later frame runs normally and reports sample_channel=0.
- Boundary CLK_DIV=8 and 31, all-ones data 12'hFFF -> SCLK period 16/62 cycles, sample=12'hFFF. The elaboration assertion fires for CLK_DIV=7.
